// File: rtl/seq_gen_param.sv
// seq_gen_param: keypad-controlled rotating pattern generator with LED view and step-count buzzer.
module seq_gen_param #(
  parameter int              SEQ_W     = 16,
  parameter int              LED_W     = 8,
  parameter logic [SEQ_W-1:0] INIT_SEQ = SEQ_W'(16'h00B8),
  parameter int              TICK_DIV  = 100_000_000,
  parameter int              MAX_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic [LED_W-1:0] led,
  output logic             buzzer,
  output logic             busy,
  output logic             dir
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d, rot;
  logic [DW-1:0]    div_q, div_d;
  logic [SW-1:0]    step_q, step_d, step_inc;
  logic             dir_q, dir_d, busy_q, busy_d, buzzer_q, buzzer_d;
  logic             k_reload, k_run, k_pause, k_dir, tick, shift;

  assign k_reload = key_valid && key_code == 5'd0;
  assign k_run    = key_valid && key_code == 5'd15;
  assign k_pause  = key_valid && key_code == 5'd14;
  assign k_dir    = key_valid && key_code == 5'd13;
  assign tick     = state_q == RUN && div_q == DW'(TICK_DIV - 1);
  // A coincident PAUSE or RELOAD suppresses the tick's shift.
  assign shift    = tick && !k_reload && !k_pause;
  assign rot      = dir_q ? {seq_q[0], seq_q[SEQ_W-1:1]} : {seq_q[SEQ_W-2:0], seq_q[SEQ_W-1]};
  assign step_inc = step_q + 1'b1;

  assign seq_d  = k_reload ? INIT_SEQ : shift ? rot : seq_q;
  assign div_d  = (k_reload || state_q == IDLE) ? '0 :
                  (state_q == RUN && !k_pause) ? (tick ? '0 : div_q + 1'b1) : div_q;
  assign step_d = k_reload ? '0 : (shift && MAX_STEPS != 0) ? step_inc : step_q;
  assign dir_d  = dir_q ^ k_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seq_q    <= INIT_SEQ;
      div_q    <= '0;
      step_q   <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      div_q    <= div_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      buzzer_q <= buzzer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (k_reload) state_d = IDLE;
    else if ((state_q == IDLE || state_q == PAUSE) && k_run) state_d = RUN;
    else if (state_q == RUN && k_pause) state_d = PAUSE;
    else if (tick && MAX_STEPS != 0 && step_inc == SW'(MAX_STEPS)) state_d = DONE;
  end

  // Flags are registered from the next state so they switch on the same edge as the FSM.
  always_comb begin
    busy_d   = state_d == RUN;
    buzzer_d = state_d == DONE;
  end

  assign led    = seq_q[SEQ_W-1 -: LED_W];
  assign buzzer = buzzer_q;
  assign busy   = busy_q;
  assign dir    = dir_q;
endmodule

// File: tb/tb_seq_gen_param.sv
// tb_seq_gen_param: table-driven checks of seq_gen_param plus hand-written reset and MAX_STEPS=0 sequences.
module tb_seq_gen_param;
  logic       clk = 1'b0;
  logic       rst_n, kv, kv0;
  logic [4:0] kc, kc0;
  logic [7:0] led, led0;
  logic       bz, busy, dir, bz0, busy0, dir0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] c;
    logic [7:0] led;
    logic       bz;
    logic       busy;
    logic       dir;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_gen_param #(.SEQ_W(16), .LED_W(8), .INIT_SEQ(16'h00B8), .TICK_DIV(4), .MAX_STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(kv), .key_code(kc),
    .led(led), .buzzer(bz), .busy(busy), .dir(dir));

  seq_gen_param #(.SEQ_W(16), .LED_W(8), .INIT_SEQ(16'h00B8), .TICK_DIV(4), .MAX_STEPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv0), .key_code(kc0),
    .led(led0), .buzzer(bz0), .busy(busy0), .dir(dir0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(logic v, logic [4:0] c, logic [7:0] l, logic b, logic bs, logic d);
    tbl.push_back('{v, c, l, b, bs, d});
  endfunction

  function automatic void key(logic [4:0] c, logic [7:0] l, logic b, logic bs, logic d);
    push(1'b1, c, l, b, bs, d);
  endfunction

  function automatic void idle(int n, logic [7:0] l, logic b, logic bs, logic d);
    repeat (n) push(1'b0, 5'd16, l, b, bs, d);
  endfunction

  // RUN from IDLE with the default pattern: eight left shifts four cycles apart, then DONE.
  function automatic void run_to_done();
    logic [7:0] l1 [9];
    l1 = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0B, 8'h17, 8'h2E, 8'h5C, 8'hB8};
    key(5'd15, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) idle(1, l1[(i / 4 > 8) ? 8 : i / 4], i >= 32, i < 32, 1'b0);
  endfunction

  function automatic void build();
    run_to_done();
    key(5'd15, 8'hB8, 1, 0, 0);
    key(5'd14, 8'hB8, 1, 0, 0);
    key(5'd13, 8'hB8, 1, 0, 1);
    key(5'd5,  8'hB8, 1, 0, 1);
    key(5'd13, 8'hB8, 1, 0, 0);
    key(5'd0,  8'h00, 0, 0, 0);
    run_to_done();
    key(5'd0,  8'h00, 0, 0, 0);
    // pause after two shifts with one cycle counted, resume, finish
    key(5'd15, 8'h00, 0, 1, 0);
    idle(3, 8'h00, 0, 1, 0);
    idle(4, 8'h01, 0, 1, 0);
    idle(2, 8'h02, 0, 1, 0);
    key(5'd14, 8'h02, 0, 0, 0);
    idle(20, 8'h02, 0, 0, 0);
    key(5'd15, 8'h02, 0, 1, 0);
    idle(2, 8'h02, 0, 1, 0);
    idle(4, 8'h05, 0, 1, 0);
    idle(4, 8'h0B, 0, 1, 0);
    idle(4, 8'h17, 0, 1, 0);
    idle(4, 8'h2E, 0, 1, 0);
    idle(4, 8'h5C, 0, 1, 0);
    idle(3, 8'hB8, 1, 0, 0);
    key(5'd0,  8'h00, 0, 0, 0);
    // PAUSE and DIR landing on the tick cycle
    key(5'd15, 8'h00, 0, 1, 0);
    idle(3, 8'h00, 0, 1, 0);
    key(5'd14, 8'h00, 0, 0, 0);
    key(5'd15, 8'h00, 0, 1, 0);
    idle(1, 8'h01, 0, 1, 0);
    idle(3, 8'h01, 0, 1, 0);
    key(5'd13, 8'h02, 0, 1, 1);
    idle(3, 8'h02, 0, 1, 1);
    idle(1, 8'h01, 0, 1, 1);
    // RELOAD mid-RUN keeps dir; RELOAD on a tick cycle suppresses the shift
    key(5'd0,  8'h00, 0, 0, 1);
    key(5'd13, 8'h00, 0, 0, 0);
    key(5'd15, 8'h00, 0, 1, 0);
    idle(3, 8'h00, 0, 1, 0);
    key(5'd0,  8'h00, 0, 0, 0);
    key(5'd15, 8'h00, 0, 1, 0);
    idle(3, 8'h00, 0, 1, 0);
    idle(1, 8'h01, 0, 1, 0);
    // ignored codes while running
    for (int c = 1; c <= 3; c++) key(5'(c), 8'h01, 0, 1, 0);
    key(5'd4, 8'h02, 0, 1, 0);
    for (int c = 5; c <= 7; c++) key(5'(c), 8'h02, 0, 1, 0);
    key(5'd8, 8'h05, 0, 1, 0);
    for (int c = 9; c <= 11; c++) key(5'(c), 8'h05, 0, 1, 0);
    key(5'd12, 8'h0B, 0, 1, 0);
    key(5'd16, 8'h0B, 0, 1, 0);
    key(5'd16, 8'h0B, 0, 1, 0);
    key(5'd13, 8'h0B, 0, 1, 1);
    idle(1, 8'h05, 0, 1, 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r_led [17];
    r_led = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hC0, 8'hE0, 8'h70, 8'hB8,
              8'h5C, 8'h2E, 8'h17, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
    rst_n = 1'b1; kv = 1'b0; kc = 5'd16; kv0 = 1'b0; kc0 = 5'd16;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset led", led, 8'h00);
    chk("reset buzzer", bz, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset dir", dir, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", busy, 1'b0);
    build();
    foreach (tbl[i]) begin
      kv = tbl[i].v;
      kc = tbl[i].c;
      @(negedge clk);
      chk($sformatf("row%0d led", i), led, tbl[i].led);
      chk($sformatf("row%0d buzzer", i), bz, tbl[i].bz);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d dir", i), dir, tbl[i].dir);
    end
    kv = 1'b0; kc = 5'd16;
    // asynchronous reset pulse between edges while running right
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("async led", led, 8'h00);
    chk("async busy", busy, 1'b0);
    chk("async dir", dir, 1'b0);
    chk("async seq", dut.seq_q, 16'h00B8);
    @(negedge clk);
    chk("release edge busy", busy, 1'b0);
    chk("release edge led", led, 8'h00);
    foreach (tbl[i]) if (i < 3) begin
      kv = 1'b1;
      kc = (i == 0) ? 5'd1 : (i == 1) ? 5'd16 : 5'd12;
      @(negedge clk);
      chk($sformatf("idle ignore%0d busy", i), busy, 1'b0);
      chk($sformatf("idle ignore%0d led", i), led, 8'h00);
    end
    kv = 1'b0; kc = 5'd16;
    // MAX_STEPS = 0: DIR before RUN, right rotation forever, never DONE
    kv0 = 1'b1; kc0 = 5'd13;
    @(negedge clk);
    chk("m0 dir", dir0, 1'b1);
    chk("m0 idle busy", busy0, 1'b0);
    kc0 = 5'd15;
    @(negedge clk);
    chk("m0 run busy", busy0, 1'b1);
    kv0 = 1'b0; kc0 = 5'd16;
    for (int t = 1; t <= 16; t++) begin
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("m0 tick%0d buzzer", t), bz0, 1'b0);
      end
      chk($sformatf("m0 tick%0d led", t), led0, r_led[t]);
      if (t == 1) chk("m0 seq tick1", dut0.seq_q, 16'h005C);
      if (t == 4) chk("m0 seq tick4", dut0.seq_q, 16'h800B);
    end
    chk("m0 lossless seq", dut0.seq_q, 16'h00B8);
    repeat (40) begin
      @(negedge clk);
      chk("m0 late buzzer", bz0, 1'b0);
    end
    chk("m0 late busy", busy0, 1'b1);
    chk("main idle busy", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
